// File: rtl/uart_rx_core_if.sv
// uart_rx_core_if: serial input and received-word outputs of the UART receiver
interface uart_rx_core_if #(parameter int NB_DATA = 8);
  logic rx_data;
  logic tick;
  logic [NB_DATA-1:0] data;
  logic valid;
  logic frame_err;
  modport master (input rx_data, output tick, data, valid, frame_err);
  modport slave (output rx_data, input tick, data, valid, frame_err);
endinterface

// File: rtl/uart_rx_core.sv
// uart_rx_core: 16x-oversampled UART receiver with glitch-rejecting start detection
module uart_rx_core #(
  parameter int NB_DATA = 8,
  parameter int DVSR = 611,
  parameter int NB_DVSR = 10,
  parameter int SB_TICK = 16
) (
  input logic i_clk,
  input logic i_reset,
  uart_rx_core_if.master bus
);
  localparam int NB_S = SB_TICK > 16 ? $clog2(SB_TICK) : 4;
  localparam int NB_N = NB_DATA > 1 ? $clog2(NB_DATA) : 1;
  localparam logic [1:0] IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3;
  logic [NB_DVSR-1:0] cnt;
  logic [1:0] sync;
  logic [1:0] state;
  logic [NB_S-1:0] s;
  logic [NB_N-1:0] n;
  logic [NB_DATA-1:0] sr, data_q;
  logic valid_q, err_q, tick, rxs;
  assign tick = cnt == NB_DVSR'(DVSR - 1);
  assign rxs = sync[1];
  assign bus.tick = tick;
  assign bus.data = data_q;
  assign bus.valid = valid_q;
  assign bus.frame_err = err_q;
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      cnt <= '0;
      sync <= 2'b11;
      state <= IDLE;
      s <= '0;
      n <= '0;
      sr <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      sync <= {sync[0], bus.rx_data};
      valid_q <= 1'b0;
      case (state)
        IDLE:
          if (!rxs) begin
            state <= START;
            s <= '0;
          end
        START:
          if (tick) begin
            // a line that is high again at mid start bit was only a glitch
            if (s == NB_S'(7)) begin
              state <= rxs ? IDLE : DATA;
              s <= '0;
              n <= '0;
            end else
              s <= s + 1'b1;
          end
        DATA:
          if (tick) begin
            if (s == NB_S'(15)) begin
              sr <= {rxs, sr[NB_DATA-1:1]};
              s <= '0;
              if (n == NB_N'(NB_DATA - 1))
                state <= STOP;
              else
                n <= n + 1'b1;
            end else
              s <= s + 1'b1;
          end
        STOP:
          if (tick) begin
            if (s == NB_S'(SB_TICK - 1)) begin
              data_q <= sr;
              valid_q <= 1'b1;
              err_q <= ~rxs;
              state <= IDLE;
            end else
              s <= s + 1'b1;
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed frames with a scoreboard monitor on the valid strobe
module tb_uart_rx_core;
  localparam int NB_DATA = 8, DVSR = 10, NB_DVSR = 4, SB_TICK = 16, BIT = 161;
  typedef struct packed {logic [7:0] data; logic err;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0, fails = 0, nvalid = 0;
  exp_t q[$];
  always #5 clk = ~clk;
  uart_rx_core_if #(.NB_DATA(NB_DATA)) u_if ();
  uart_rx_core #(.NB_DATA(NB_DATA), .DVSR(DVSR), .NB_DVSR(NB_DVSR), .SB_TICK(SB_TICK))
    dut (.i_clk(clk), .i_reset(rst_n), .bus(u_if));
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic line(input logic v, input int cyc);
    u_if.rx_data = v;
    repeat (cyc) @(negedge clk);
  endtask
  task automatic send_frame(input logic [7:0] b, input logic stop);
    q.push_back({b, ~stop});
    line(1'b0, BIT);
    for (int i = 0; i < 8; i++) line(b[i], BIT);
    if (stop) line(1'b1, BIT);
    else begin
      line(1'b0, 81);
      line(1'b1, BIT - 81);
    end
  endtask
  task automatic wait_tick(output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (u_if.tick !== 1'b1 && k < 4 * DVSR);
  endtask
  always @(negedge clk) begin : monitor
    exp_t e;
    if (u_if.valid === 1'b1) begin
      nvalid++;
      if (q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_valid: got data %0h with nothing expected", u_if.data);
      end else begin
        e = q.pop_front();
        check("rx_data", 32'(u_if.data), 32'(e.data));
        check("rx_frame_err", 32'(u_if.frame_err), 32'(e.err));
      end
    end
  end
  initial begin
    int k;
    u_if.rx_data = 1'b1;
    repeat (20) @(negedge clk);
    check("rst_tick", 32'(u_if.tick), 0);
    check("rst_data", 32'(u_if.data), 0);
    check("rst_valid", 32'(u_if.valid), 0);
    check("rst_frame_err", 32'(u_if.frame_err), 0);
    rst_n = 1'b1;
    wait_tick(k);
    check("first_tick_latency", 32'(k >= DVSR - 1 && k <= DVSR), 1);
    for (int i = 0; i < 3; i++) begin
      wait_tick(k);
      check("tick_period", 32'(k), DVSR);
    end
    @(negedge clk);
    check("tick_one_cycle", 32'(u_if.tick), 0);
    line(1'b0, 60);
    line(1'b1, 200);
    check("glitch_data", 32'(u_if.data), 0);
    check("glitch_no_valid", 32'(nvalid), 0);
    send_frame(8'h4F, 1'b1);
    line(1'b1, 100);
    send_frame(8'h4F, 1'b0);
    line(1'b1, 300);
    check("frame_err_held", 32'(u_if.frame_err), 1);
    check("valid_count_err", 32'(nvalid), 2);
    send_frame(8'h55, 1'b1);
    send_frame(8'hA3, 1'b1);
    line(1'b1, 300);
    check("valid_count_b2b", 32'(nvalid), 4);
    line(1'b0, BIT);
    for (int i = 0; i < 4; i++) line(k[i] ^ 1'b1, BIT);
    line(1'b0, 80);
    rst_n = 1'b0;
    u_if.rx_data = 1'b1;
    repeat (5) @(negedge clk);
    check("midrst_data", 32'(u_if.data), 0);
    check("midrst_frame_err", 32'(u_if.frame_err), 0);
    rst_n = 1'b1;
    line(1'b1, 400);
    check("midrst_no_valid", 32'(nvalid), 4);
    send_frame(8'h3C, 1'b1);
    line(1'b1, 300);
    check("queue_drained", 32'(q.size()), 0);
    check("valid_count_total", 32'(nvalid), 5);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
